// File: rtl/pe_seq_pkg.sv
// Shared types and helpers for the PE cluster pass sequencer.
package pe_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WGHT,
    IACT,
    COMPUTE,
    WAIT,
    DRAIN,
    DONE
  } seq_state_e;

  localparam int NUM_GLB_IACT_DEF = 3;
  // The idle select code is one past the last valid iact lane index.
  localparam int IACT_IDLE_CODE   = NUM_GLB_IACT_DEF;

  function automatic int choose_w(input int num_glb_iact);
    return (num_glb_iact < 1) ? 1 : $clog2(num_glb_iact + 1);
  endfunction

endpackage

// File: rtl/pe_seq_lockstep_hs.sv
// N-lane valid/ready join: all lanes transfer together or none do.
module pe_seq_lockstep_hs #(
  parameter int LANES = 3
) (
  input  logic             active,
  input  logic [LANES-1:0] glb_valid,
  input  logic [LANES-1:0] pe_ready,
  output logic [LANES-1:0] pe_enable,
  output logic [LANES-1:0] glb_ready
);

  assign pe_enable = {LANES{active & (&glb_valid)}};
  assign glb_ready = {LANES{active & (&pe_ready)}};

endmodule

// File: rtl/pe_cluster_sequencer.sv
// Sequences one PE cluster pass: weight load, diagonal iact load, compute,
// fixed wait and psum drain. Cluster data buses bypass this block.
module pe_cluster_sequencer
  import pe_seq_pkg::*;
#(
  parameter int NUM_GLB_IACT = NUM_GLB_IACT_DEF,
  parameter int NUM_GLB_WGHT = 3,
  parameter int NUM_GLB_PSUM = 4,
  parameter int PE_ROWS      = 3,
  parameter int PE_COLUMNS   = 4,
  parameter int CNT_W        = 8,
  localparam int CW          = choose_w(NUM_GLB_IACT),
  localparam int NUM_PE      = PE_ROWS * PE_COLUMNS
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [CNT_W-1:0]       cfg_wght_words_i,
  input  logic [CNT_W-1:0]       cfg_iact_words_i,
  input  logic [CNT_W-1:0]       cfg_iact_groups_i,
  input  logic [CNT_W-1:0]       cfg_compute_cyc_i,
  input  logic [CNT_W-1:0]       cfg_psum_words_i,
  input  logic [NUM_GLB_WGHT-1:0] glb_wght_valid_i,
  output logic [NUM_GLB_WGHT-1:0] glb_wght_ready_o,
  output logic [NUM_GLB_WGHT-1:0] pe_wght_enable_o,
  input  logic [NUM_GLB_WGHT-1:0] pe_wght_ready_i,
  input  logic [NUM_GLB_IACT-1:0] glb_iact_valid_i,
  output logic [NUM_GLB_IACT-1:0] glb_iact_ready_o,
  output logic [NUM_GLB_IACT-1:0] pe_iact_enable_o,
  input  logic [NUM_GLB_IACT-1:0] pe_iact_ready_i,
  output logic [NUM_PE*CW-1:0]   iact_choose_o,
  output logic [NUM_PE-1:0]      compute_o,
  output logic [NUM_GLB_PSUM-1:0] psum_choose_o,
  output logic [NUM_GLB_PSUM-1:0] pe_router_psum_enable_o,
  input  logic [NUM_GLB_PSUM-1:0] pe_router_psum_ready_i,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int                 CH_W         = NUM_PE * CW;
  localparam logic [CNT_W-1:0]   CNT_ONE      = CNT_W'(1);
  localparam logic [CW-1:0]      IDLE_CODE    = CW'(NUM_GLB_IACT);
  localparam logic [CH_W-1:0]    IDLE_PATTERN = {NUM_PE{IDLE_CODE}};

  seq_state_e state, state_nxt;

  logic [CNT_W-1:0] wght_words, iact_words, iact_groups, compute_cyc, psum_words;
  logic [CNT_W-1:0] wght_cnt, word_cnt, grp_cnt, wait_cnt, psum_cnt;

  logic                    wght_beat, iact_beat, psum_beat;
  logic                    wght_last, word_last, grp_last, wait_last, psum_last;
  logic [NUM_GLB_PSUM-1:0] psum_grant;

  // PE (c,r) sits on diagonal c+r; group g feeds diagonals g*N .. g*N+N-1.
  function automatic logic [CH_W-1:0] diag_pattern(input logic [CNT_W-1:0] grp);
    logic [CH_W-1:0] pat;
    int              base;
    int              diag;
    pat  = IDLE_PATTERN;
    base = int'(grp) * NUM_GLB_IACT;
    for (int c = 0; c < PE_COLUMNS; c++) begin
      for (int r = 0; r < PE_ROWS; r++) begin
        diag = c + r;
        if (diag >= base && diag < base + NUM_GLB_IACT)
          pat[(c*PE_ROWS + r)*CW +: CW] = CW'(diag - base);
      end
    end
    return pat;
  endfunction

  function automatic seq_state_e after_wght(input logic [CNT_W-1:0] iw,
                                            input logic [CNT_W-1:0] ig);
    return (iw != '0 && ig != '0) ? IACT : COMPUTE;
  endfunction

  function automatic seq_state_e after_wait(input logic [CNT_W-1:0] pw);
    return (pw != '0) ? DRAIN : DONE;
  endfunction

  pe_seq_lockstep_hs #(.LANES(NUM_GLB_WGHT)) u_wght_hs (
    .active    (state == WGHT),
    .glb_valid (glb_wght_valid_i),
    .pe_ready  (pe_wght_ready_i),
    .pe_enable (pe_wght_enable_o),
    .glb_ready (glb_wght_ready_o)
  );

  pe_seq_lockstep_hs #(.LANES(NUM_GLB_IACT)) u_iact_hs (
    .active    (state == IACT),
    .glb_valid (glb_iact_valid_i),
    .pe_ready  (pe_iact_ready_i),
    .pe_enable (pe_iact_enable_o),
    .glb_ready (glb_iact_ready_o)
  );

  // The drain side has no upstream valid; the router ready alone gates it.
  pe_seq_lockstep_hs #(.LANES(NUM_GLB_PSUM)) u_psum_hs (
    .active    (state == DRAIN),
    .glb_valid ({NUM_GLB_PSUM{1'b1}}),
    .pe_ready  (pe_router_psum_ready_i),
    .pe_enable (pe_router_psum_enable_o),
    .glb_ready (psum_grant)
  );

  assign wght_beat = (&pe_wght_enable_o) & (&glb_wght_ready_o);
  assign iact_beat = (&pe_iact_enable_o) & (&glb_iact_ready_o);
  assign psum_beat = &psum_grant;

  assign wght_last = wght_beat && (wght_cnt == wght_words - CNT_ONE);
  assign word_last = (word_cnt == iact_words - CNT_ONE);
  assign grp_last  = (grp_cnt == iact_groups - CNT_ONE);
  assign wait_last = (wait_cnt == compute_cyc - CNT_ONE);
  assign psum_last = psum_beat && (psum_cnt == psum_words - CNT_ONE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_i)
                 state_nxt = (cfg_wght_words_i != '0) ? WGHT
                           : after_wght(cfg_iact_words_i, cfg_iact_groups_i);
      WGHT:    if (wght_last) state_nxt = after_wght(iact_words, iact_groups);
      IACT:    if (iact_beat && word_last && grp_last) state_nxt = COMPUTE;
      COMPUTE: state_nxt = (compute_cyc != '0) ? WAIT : after_wait(psum_words);
      WAIT:    if (wait_last) state_nxt = after_wait(psum_words);
      DRAIN:   if (psum_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort_i) state_nxt = IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      wght_words    <= '0;
      iact_words    <= '0;
      iact_groups   <= '0;
      compute_cyc   <= '0;
      psum_words    <= '0;
      wght_cnt      <= '0;
      word_cnt      <= '0;
      grp_cnt       <= '0;
      wait_cnt      <= '0;
      psum_cnt      <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      compute_o     <= '0;
      psum_choose_o <= '0;
      iact_choose_o <= IDLE_PATTERN;
    end else begin
      state         <= state_nxt;
      busy_o        <= (state_nxt != IDLE);
      done_o        <= (state_nxt == DONE);
      compute_o     <= {NUM_PE{state_nxt == COMPUTE}};
      psum_choose_o <= {NUM_GLB_PSUM{state_nxt == DRAIN}};

      if (state == IDLE && start_i && !abort_i) begin
        wght_words  <= cfg_wght_words_i;
        iact_words  <= cfg_iact_words_i;
        iact_groups <= cfg_iact_groups_i;
        compute_cyc <= cfg_compute_cyc_i;
        psum_words  <= cfg_psum_words_i;
      end

      unique case (state)
        WGHT:  if (wght_beat) wght_cnt <= wght_last ? '0 : wght_cnt + CNT_ONE;
        IACT:  if (iact_beat) begin
                 if (word_last) begin
                   word_cnt <= '0;
                   grp_cnt  <= grp_last ? '0 : grp_cnt + CNT_ONE;
                 end else begin
                   word_cnt <= word_cnt + CNT_ONE;
                 end
               end
        WAIT:  wait_cnt <= wait_last ? '0 : wait_cnt + CNT_ONE;
        DRAIN: if (psum_beat) psum_cnt <= psum_last ? '0 : psum_cnt + CNT_ONE;
        default: ;
      endcase

      // Abort or pass end leaves every counter clean for the next start.
      if (state_nxt == IDLE) begin
        wght_cnt <= '0;
        word_cnt <= '0;
        grp_cnt  <= '0;
        wait_cnt <= '0;
        psum_cnt <= '0;
      end

      // Pattern for a group is loaded one edge ahead of its first beat.
      if (state_nxt != IACT)
        iact_choose_o <= IDLE_PATTERN;
      else if (state != IACT)
        iact_choose_o <= diag_pattern('0);
      else if (iact_beat && word_last)
        iact_choose_o <= diag_pattern(grp_cnt + CNT_ONE);
    end
  end

endmodule

// File: tb/tb_pe_cluster_sequencer.sv
// Scoreboard bench for pe_cluster_sequencer: directed passes push expected
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_pe_cluster_sequencer;

  localparam int NI = 3, NW = 3, NP = 4, NPE = 12, CNT_W = 8;

  localparam logic [2:0] EV_W = 3'd0, EV_I = 3'd1, EV_C = 3'd2, EV_P = 3'd3, EV_D = 3'd4;

  // Hand-derived select patterns, field (c*3+r) holds PE(c,r), idle code 3.
  localparam logic [23:0] PAT_G0   = 24'hFFEE64;
  localparam logic [23:0] PAT_G1   = 24'h9133FF;
  localparam logic [23:0] PAT_IDLE = 24'hFFFFFF;

  logic clk = 1'b0;
  logic rst;
  logic start, abort_s;
  logic [CNT_W-1:0] cfg_w, cfg_iw, cfg_ig, cfg_cc, cfg_pw;
  logic [NW-1:0] glb_wght_valid, glb_wght_ready, pe_wght_enable, pe_wght_ready;
  logic [NI-1:0] glb_iact_valid, glb_iact_ready, pe_iact_enable, pe_iact_ready;
  logic [23:0]   iact_choose;
  logic [NPE-1:0] compute;
  logic [NP-1:0] psum_choose, router_en, router_rdy;
  logic busy, done;

  always #5 clk = ~clk;

  pe_cluster_sequencer dut (
    .clk_i                   (clk),
    .rst_i                   (rst),
    .start_i                 (start),
    .abort_i                 (abort_s),
    .cfg_wght_words_i        (cfg_w),
    .cfg_iact_words_i        (cfg_iw),
    .cfg_iact_groups_i       (cfg_ig),
    .cfg_compute_cyc_i       (cfg_cc),
    .cfg_psum_words_i        (cfg_pw),
    .glb_wght_valid_i        (glb_wght_valid),
    .glb_wght_ready_o        (glb_wght_ready),
    .pe_wght_enable_o        (pe_wght_enable),
    .pe_wght_ready_i         (pe_wght_ready),
    .glb_iact_valid_i        (glb_iact_valid),
    .glb_iact_ready_o        (glb_iact_ready),
    .pe_iact_enable_o        (pe_iact_enable),
    .pe_iact_ready_i         (pe_iact_ready),
    .iact_choose_o           (iact_choose),
    .compute_o               (compute),
    .psum_choose_o           (psum_choose),
    .pe_router_psum_enable_o (router_en),
    .pe_router_psum_ready_i  (router_rdy),
    .busy_o                  (busy),
    .done_o                  (done)
  );

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0, n_fail = 0;
  int  cyc = 0, wen_cyc = 0, drain_cyc = 0, iact_beats = 0, done_cnt = 0;
  int  compute_at = 0, done_at = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic got(input logic [2:0] kind, input logic [31:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d data %0h, expected none (cycle %0d)", kind, data, cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(kind), 32'(e.kind));
      check("event_data", data, e.data);
    end
  endtask

  task automatic push(input logic [2:0] k, input logic [31:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic expect_pass(input int w, input int iw, input int ig, input int pw);
    repeat (w) push(EV_W, 32'h0);
    if (iw != 0 && ig != 0)
      for (int g = 0; g < ig; g++)
        repeat (iw) push(EV_I, (g == 0) ? 32'(PAT_G0) : 32'(PAT_G1));
    push(EV_C, 32'hFFF);
    repeat (pw) push(EV_P, 32'hF);
    push(EV_D, 32'h0);
  endtask

  task automatic launch(input int w, input int iw, input int ig, input int cc, input int pw);
    @(posedge clk); #1;
    cfg_w  = CNT_W'(w);
    cfg_iw = CNT_W'(iw);
    cfg_ig = CNT_W'(ig);
    cfg_cc = CNT_W'(cc);
    cfg_pw = CNT_W'(pw);
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done_cnt != d0) break;
    end
    check(name, 32'(done_cnt - d0), 32'd1);
    @(posedge clk); #1;
    check({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  task automatic check_idle(input string name);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_compute"}, 32'(compute), 32'd0);
    check({name, "_psum_choose"}, 32'(psum_choose), 32'd0);
    check({name, "_router_en"}, 32'(router_en), 32'd0);
    check({name, "_iact_choose"}, 32'(iact_choose), 32'(PAT_IDLE));
    check({name, "_wght_en_rdy"}, 32'({pe_wght_enable, glb_wght_ready}), 32'd0);
    check({name, "_iact_en_rdy"}, 32'({pe_iact_enable, glb_iact_ready}), 32'd0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every DUT transfer or pulse is matched against the queue head.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (&pe_wght_enable && &glb_wght_ready) got(EV_W, 32'h0);
      if (&pe_iact_enable && &glb_iact_ready) begin
        got(EV_I, 32'(iact_choose));
        iact_beats++;
      end
      if (compute != '0) begin
        got(EV_C, 32'(compute));
        compute_at = cyc;
      end
      if (&router_en && &router_rdy) got(EV_P, 32'(psum_choose));
      if (done) begin
        got(EV_D, 32'h0);
        done_cnt++;
        done_at = cyc;
      end
      if (|pe_wght_enable) wen_cyc++;
      if (|psum_choose) drain_cyc++;
    end
  end

  initial begin
    int b0, w0, dr0, d0;
    logic prev_choose;
    rst = 1'b1;
    start = 1'b0;
    abort_s = 1'b0;
    cfg_w = '0; cfg_iw = '0; cfg_ig = '0; cfg_cc = '0; cfg_pw = '0;
    glb_wght_valid = '1; pe_wght_ready = '1;
    glb_iact_valid = '1; pe_iact_ready = '1;
    router_rdy = '1;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;

    // 1: weight load only, compute pulse, wait and drain skipped
    w0 = wen_cyc;
    expect_pass(4, 0, 0, 0);
    launch(4, 0, 0, 0, 0);
    wait_done("t1_done", 30);
    check("t1_wght_enable_cycles", 32'(wen_cyc - w0), 32'd4);
    check("t1_done_after_compute", 32'(done_at - compute_at), 32'd1);

    // 2: two diagonal groups of 8 beats
    b0 = iact_beats;
    expect_pass(0, 8, 2, 0);
    launch(0, 8, 2, 0, 0);
    wait_done("t2_done", 60);
    check("t2_iact_beats", 32'(iact_beats - b0), 32'd16);
    check("t2_choose_idle", 32'(iact_choose), 32'(PAT_IDLE));

    // 3: one PE lane stalls for 5 cycles mid-group
    b0 = iact_beats;
    expect_pass(0, 8, 2, 0);
    launch(0, 8, 2, 0, 0);
    for (int i = 0; i < 30 && iact_beats != b0 + 3; i++) begin
      @(negedge clk); #1;
    end
    check("t3_reach_3_beats", 32'(iact_beats - b0), 32'd3);
    @(posedge clk); #1;
    pe_iact_ready[1] = 1'b0;
    repeat (5) begin
      @(negedge clk); #1;
      check("t3_stall_glb_ready", 32'(glb_iact_ready), 32'd0);
      check("t3_stall_enable", 32'(pe_iact_enable), 32'h7);
    end
    check("t3_stall_no_advance", 32'(iact_beats - b0), 32'd3);
    @(posedge clk); #1;
    pe_iact_ready[1] = 1'b1;
    wait_done("t3_done", 60);
    check("t3_iact_beats", 32'(iact_beats - b0), 32'd16);

    // 4: drain with router ready toggling, starting low
    dr0 = drain_cyc;
    d0 = done_cnt;
    router_rdy = '0;
    expect_pass(0, 0, 0, 8);
    launch(0, 0, 0, 0, 8);
    prev_choose = 1'b0;
    for (int i = 0; i < 60 && done_cnt == d0; i++) begin
      @(posedge clk); #1;
      if (prev_choose) router_rdy = ~router_rdy;
      prev_choose = psum_choose[0];
    end
    router_rdy = '1;
    check("t4_done_seen", 32'(done_cnt - d0), 32'd1);
    check("t4_drain_cycles", 32'(drain_cyc - dr0), 32'd16);
    @(posedge clk); #1;
    check("t4_queue_left", 32'(exp_q.size()), 32'd0);

    // 5: abort after 3 iact beats, then a full pass
    b0 = iact_beats;
    d0 = done_cnt;
    repeat (3) push(EV_I, 32'(PAT_G0));
    launch(0, 8, 2, 0, 0);
    for (int i = 0; i < 30 && iact_beats != b0 + 3; i++) begin
      @(negedge clk); #1;
    end
    abort_s = 1'b1;
    @(posedge clk); #1;
    abort_s = 1'b0;
    check_idle("t5_abort");
    repeat (4) @(posedge clk);
    #1;
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);
    check("t5_abort_beats", 32'(iact_beats - b0), 32'd3);
    check("t5_queue_left", 32'(exp_q.size()), 32'd0);
    expect_pass(2, 8, 1, 4);
    launch(2, 8, 1, 2, 4);
    wait_done("t5_restart_done", 60);

    // 6a: start held while busy, cfg changed after latch
    expect_pass(0, 0, 0, 4);
    @(posedge clk); #1;
    cfg_w = '0; cfg_iw = '0; cfg_ig = '0; cfg_cc = 8'd3; cfg_pw = 8'd4;
    start = 1'b1;
    @(posedge clk); #1;
    cfg_pw = 8'd9;
    repeat (4) begin
      @(negedge clk); #1;
      check("t6_busy_while_start", 32'(busy), 32'd1);
      @(posedge clk); #1;
    end
    start = 1'b0;
    wait_done("t6_done", 40);

    // 6b: asynchronous reset in the middle of WAIT
    push(EV_C, 32'hFFF);
    launch(0, 0, 0, 20, 0);
    repeat (4) @(posedge clk);
    #3;
    check("t6_busy_in_wait", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_idle("t6_async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    check("t6_queue_left", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_idle("t6_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
